// File: rtl/issue_perf_counters.sv
// Issue-stage perf event counters: free-running, wrap-around stall and active-thread counts.
// Optional macro ISSUE_PERF_FPU_EN enables the fpu stall counter; otherwise fpu_stalls reads 0.
module issue_perf_counters #(
    parameter int CTR_BITS    = 44,
    parameter int NUM_THREADS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_decode_valid,
    input  logic                   i_ibuf_ready,
    input  logic                   i_ibuf_valid,
    input  logic                   i_scb_ready,
    input  logic [4:0]             i_disp_valid,
    input  logic [4:0]             i_disp_ready,
    input  logic                   i_issue_valid,
    input  logic                   i_issue_ready,
    input  logic [NUM_THREADS-1:0] i_issue_tmask,
    output logic [CTR_BITS-1:0]    o_ibf_stalls,
    output logic [CTR_BITS-1:0]    o_scb_stalls,
    output logic [CTR_BITS-1:0]    o_lsu_stalls,
    output logic [CTR_BITS-1:0]    o_csr_stalls,
    output logic [CTR_BITS-1:0]    o_alu_stalls,
    output logic [CTR_BITS-1:0]    o_fpu_stalls,
    output logic [CTR_BITS-1:0]    o_gpu_stalls,
    output logic [CTR_BITS-1:0]    o_active_threads
);

    localparam int PC_BITS = $clog2(NUM_THREADS + 1);
    localparam logic [CTR_BITS-1:0] ONE = CTR_BITS'(1);

    logic                w_ibf_evt;
    logic                w_scb_evt;
    logic                w_lsu_evt;
    logic                w_csr_evt;
    logic                w_alu_evt;
    logic                w_gpu_evt;
    logic                w_fire;
    logic [PC_BITS-1:0]  w_popcnt;

    logic [CTR_BITS-1:0] r_ibf;
    logic [CTR_BITS-1:0] r_scb;
    logic [CTR_BITS-1:0] r_lsu;
    logic [CTR_BITS-1:0] r_csr;
    logic [CTR_BITS-1:0] r_alu;
    logic [CTR_BITS-1:0] r_gpu;
    logic [CTR_BITS-1:0] r_act;

    assign w_ibf_evt = i_decode_valid & ~i_ibuf_ready;
    assign w_scb_evt = i_ibuf_valid & ~i_scb_ready;
    assign w_lsu_evt = i_disp_valid[0] & ~i_disp_ready[0];
    assign w_csr_evt = i_disp_valid[1] & ~i_disp_ready[1];
    assign w_alu_evt = i_disp_valid[2] & ~i_disp_ready[2];
    assign w_gpu_evt = i_disp_valid[4] & ~i_disp_ready[4];
    assign w_fire    = i_issue_valid & i_issue_ready;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_popcnt = w_popcnt + PC_BITS'(i_issue_tmask[i]);
        end
    end

    // Clear outranks any event in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ibf <= '0;
            r_scb <= '0;
            r_lsu <= '0;
            r_csr <= '0;
            r_alu <= '0;
            r_gpu <= '0;
            r_act <= '0;
        end else if (i_clear) begin
            r_ibf <= '0;
            r_scb <= '0;
            r_lsu <= '0;
            r_csr <= '0;
            r_alu <= '0;
            r_gpu <= '0;
            r_act <= '0;
        end else begin
            if (w_ibf_evt) r_ibf <= r_ibf + ONE;
            if (w_scb_evt) r_scb <= r_scb + ONE;
            if (w_lsu_evt) r_lsu <= r_lsu + ONE;
            if (w_csr_evt) r_csr <= r_csr + ONE;
            if (w_alu_evt) r_alu <= r_alu + ONE;
            if (w_gpu_evt) r_gpu <= r_gpu + ONE;
            if (w_fire)    r_act <= r_act + CTR_BITS'(w_popcnt);
        end
    end

`ifdef ISSUE_PERF_FPU_EN
    logic                w_fpu_evt;
    logic [CTR_BITS-1:0] r_fpu;

    assign w_fpu_evt = i_disp_valid[3] & ~i_disp_ready[3];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fpu <= '0;
        end else if (i_clear) begin
            r_fpu <= '0;
        end else if (w_fpu_evt) begin
            r_fpu <= r_fpu + ONE;
        end
    end

    assign o_fpu_stalls = r_fpu;
`else
    // The fpu dispatch bits are present on the port but have no consumer in this build.
    logic w_unused_fpu;
    assign w_unused_fpu = &{1'b0, i_disp_valid[3], i_disp_ready[3]};
    assign o_fpu_stalls = '0;
`endif

    assign o_ibf_stalls     = r_ibf;
    assign o_scb_stalls     = r_scb;
    assign o_lsu_stalls     = r_lsu;
    assign o_csr_stalls     = r_csr;
    assign o_alu_stalls     = r_alu;
    assign o_gpu_stalls     = r_gpu;
    assign o_active_threads = r_act;

endmodule

// File: tb/tb_issue_perf_counters.sv
// Directed bench for issue_perf_counters: cumulative vector table plus wrap, clear and async-reset sequences.
module tb_issue_perf_counters;

    localparam int CB = 44;
    localparam int CW = 4;
`ifdef ISSUE_PERF_FPU_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear, dv, ir, bv, sr, iv, irdy;
    logic [4:0]    pv, pr;
    logic [3:0]    tm;
    logic [CB-1:0] ibf, scb, lsu, csr, alu, fpu, gpu, act;
    logic [CW-1:0] n_ibf, n_scb, n_lsu, n_csr, n_alu, n_fpu, n_gpu, n_act;

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    issue_perf_counters #(.CTR_BITS(CB), .NUM_THREADS(4)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_clear(clear),
        .i_decode_valid(dv), .i_ibuf_ready(ir), .i_ibuf_valid(bv), .i_scb_ready(sr),
        .i_disp_valid(pv), .i_disp_ready(pr),
        .i_issue_valid(iv), .i_issue_ready(irdy), .i_issue_tmask(tm),
        .o_ibf_stalls(ibf), .o_scb_stalls(scb), .o_lsu_stalls(lsu), .o_csr_stalls(csr),
        .o_alu_stalls(alu), .o_fpu_stalls(fpu), .o_gpu_stalls(gpu), .o_active_threads(act)
    );

    // Narrow instance on the same inputs, used to exercise wrap-around in a few cycles.
    issue_perf_counters #(.CTR_BITS(CW), .NUM_THREADS(4)) dut_n (
        .i_clk(clk), .i_reset(rst_n), .i_clear(clear),
        .i_decode_valid(dv), .i_ibuf_ready(ir), .i_ibuf_valid(bv), .i_scb_ready(sr),
        .i_disp_valid(pv), .i_disp_ready(pr),
        .i_issue_valid(iv), .i_issue_ready(irdy), .i_issue_tmask(tm),
        .o_ibf_stalls(n_ibf), .o_scb_stalls(n_scb), .o_lsu_stalls(n_lsu), .o_csr_stalls(n_csr),
        .o_alu_stalls(n_alu), .o_fpu_stalls(n_fpu), .o_gpu_stalls(n_gpu), .o_active_threads(n_act)
    );

    typedef struct {
        logic       clr, dv, ir, bv, sr;
        logic [4:0] pv, pr;
        logic       iv, irdy;
        logic [3:0] tm;
        int         n;
        int         e_ibf, e_scb, e_lsu, e_csr, e_alu, e_fpu, e_gpu, e_act;
    } vec_t;

    localparam int NV = 16;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk_main(input string tag, input int e_ibf, input int e_scb, input int e_lsu,
                            input int e_csr, input int e_alu, input int e_fpu, input int e_gpu,
                            input int e_act);
        vecs++;
        chk({tag, ".ibf"}, 64'(ibf), 64'(e_ibf));
        chk({tag, ".scb"}, 64'(scb), 64'(e_scb));
        chk({tag, ".lsu"}, 64'(lsu), 64'(e_lsu));
        chk({tag, ".csr"}, 64'(csr), 64'(e_csr));
        chk({tag, ".alu"}, 64'(alu), 64'(e_alu));
        chk({tag, ".fpu"}, 64'(fpu), 64'(e_fpu));
        chk({tag, ".gpu"}, 64'(gpu), 64'(e_gpu));
        chk({tag, ".act"}, 64'(act), 64'(e_act));
    endtask

    task automatic idle();
        clear = 1'b0; dv = 1'b0; ir = 1'b0; bv = 1'b0; sr = 1'b0;
        pv = 5'b0; pr = 5'b0; iv = 1'b0; irdy = 1'b0; tm = 4'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //          clr   dv    ir    bv    sr    pv        pr        iv    irdy  tm       n   ibf scb lsu csr alu fpu    gpu act
        v[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 4'b0000, 10, 0, 0, 0, 0, 0, 0,     0, 0};
        v[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 4'b0000, 3,  3, 3, 0, 0, 0, 0,     0, 0};
        v[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 4'b0000, 4,  7, 3, 0, 0, 0, 0,     0, 0};
        v[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 4'b0000, 2,  7, 3, 0, 0, 0, 0,     0, 0};
        v[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b00101, 1'b0, 1'b0, 4'b0000, 4,  7, 3, 0, 4, 0, 4*FE,  4, 0};
        v[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 4'b1111, 1,  7, 3, 0, 4, 0, 4*FE,  4, 4};
        v[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 4'b0101, 1,  7, 3, 0, 4, 0, 4*FE,  4, 6};
        v[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 4'b0001, 1,  7, 3, 0, 4, 0, 4*FE,  4, 7};
        v[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 4'b1111, 1,  7, 3, 0, 4, 0, 4*FE,  4, 7};
        v[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 4'b1111, 1,  7, 3, 0, 4, 0, 4*FE,  4, 7};
        v[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1, 4'b0111, 2,  9, 5, 2, 6, 2, 6*FE,  6, 13};
        v[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11111, 5'b00000, 1'b1, 1'b1, 4'b1111, 1,  0, 0, 0, 0, 0, 0,     0, 0};
        v[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 4'b0000, 1,  0, 1, 0, 0, 0, 0,     0, 0};
        v[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01000, 5'b00000, 1'b0, 1'b0, 4'b0000, 3,  0, 1, 0, 0, 0, 3*FE,  0, 0};
        v[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b0, 4'b0000, 2,  0, 1, 0, 0, 0, 3*FE,  0, 0};
        v[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 4'b1010, 2,  0, 1, 0, 0, 0, 3*FE,  0, 4};

        idle();
        pv = 5'bxxxxx;
        pr = 5'bxxxxx;
        rst_n = 1'b0;
        cyc(3);
        chk_main("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            clear = v[k].clr; dv = v[k].dv; ir = v[k].ir; bv = v[k].bv; sr = v[k].sr;
            pv = v[k].pv; pr = v[k].pr; iv = v[k].iv; irdy = v[k].irdy; tm = v[k].tm;
            cyc(v[k].n);
            chk_main($sformatf("vec%0d", k), v[k].e_ibf, v[k].e_scb, v[k].e_lsu, v[k].e_csr,
                     v[k].e_alu, v[k].e_fpu, v[k].e_gpu, v[k].e_act);
        end

        // Stall counter wrap: all-ones plus one returns to zero on the narrow instance.
        idle(); clear = 1'b1; cyc(1);
        clear = 1'b0; dv = 1'b1; cyc(15);
        vecs++; chk("wrap.ibf_full", 64'(n_ibf), 64'd15);
        cyc(1);
        vecs++; chk("wrap.ibf_zero", 64'(n_ibf), 64'd0);
        chk("wrap.ibf_wide", 64'(ibf), 64'd16);

        // active_threads at 2^N-2 plus 4 lands on 2.
        idle(); clear = 1'b1; cyc(1);
        clear = 1'b0; iv = 1'b1; irdy = 1'b1; tm = 4'b1111; cyc(3);
        tm = 4'b0011; cyc(1);
        vecs++; chk("wrap.act_pre", 64'(n_act), 64'd14);
        tm = 4'b1111; cyc(1);
        vecs++; chk("wrap.act_wrap", 64'(n_act), 64'd2);
        chk("wrap.act_wide", 64'(act), 64'd18);

        // Clear coincident with a scb event drops that event.
        idle(); bv = 1'b1; cyc(2);
        vecs++; chk("clrpri.scb_pre", 64'(scb), 64'd2);
        clear = 1'b1; cyc(1);
        vecs++; chk("clrpri.scb", 64'(scb), 64'd0);
        clear = 1'b0; cyc(1);
        vecs++; chk("clrpri.resume", 64'(scb), 64'd1);

        // Async reset between edges while counters are nonzero.
        idle(); dv = 1'b1; iv = 1'b1; irdy = 1'b1; tm = 4'b0111; pv = 5'b10000; cyc(2);
        chk_main("pre_arst", 2, 1, 0, 0, 0, 0, 2, 6);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk_main("arst", 0, 0, 0, 0, 0, 0, 0, 0);
        vecs++; chk("arst.narrow_act", 64'(n_act), 64'd0);
        cyc(1);
        rst_n = 1'b1;
        dv = 1'b1;
        cyc(1);
        chk_main("post_arst", 1, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/issue_perf_counters.md
Name: issue_perf_counters

Overview:
- Issue-stage event counter bank; drives the issue-side counters of the pipeline perf interface: ibf/scb/lsu/csr/alu/fpu/gpu stalls and active_threads.
- Sits inside the issue stage; samples ibuffer, scoreboard and dispatch handshakes every cycle.
- Free-running wrap-around counters feed the CSR perf readout.

Parameters:
- CTR_BITS, 44: width of every counter output (matches perf counter width).
- NUM_THREADS, 4: width of issue thread mask; popcount width is clog2(NUM_THREADS+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all counters.
- decode_valid  in  1  decode presenting an instruction to ibuffer.
- ibuf_ready  in  1  ibuffer accepting.
- ibuf_valid  in  1  ibuffer head valid toward scoreboard.
- scb_ready  in  1  scoreboard has no hazard for head.
- disp_valid  in  5  per-unit dispatch request {gpu,fpu,alu,csr,lsu}, bit0 = lsu.
- disp_ready  in  5  per-unit ready, same bit order.
- issue_valid  in  1  instruction leaving issue.
- issue_ready  in  1  dispatch accepted it.
- issue_tmask  in  NUM_THREADS  thread mask of issuing instruction.
- ibf_stalls, scb_stalls, lsu_stalls, csr_stalls, alu_stalls, fpu_stalls, gpu_stalls  out  CTR_BITS each  stall cycle counts.
- active_threads  out  CTR_BITS  sum of active threads over issued instructions.

Behaviour:
- Reset: reset low asynchronously forces every output to 0; held until the first rising clk after release.
- Event definitions, evaluated each cycle:
  - ibf event = decode_valid & ~ibuf_ready.
  - scb event = ibuf_valid & ~scb_ready.
  - unit[i] event = disp_valid[i] & ~disp_ready[i].
  - issue fire = issue_valid & issue_ready.
- Latency: an event in cycle N is reflected on the output register after the clk edge ending cycle N (1-cycle latency). There is no input pipeline register.
- Stall counters increment by exactly 1 per event cycle.
- active_threads adds popcount(issue_tmask) on each fire cycle. The popcount is zero-extended to CTR_BITS. issue_tmask is ignored when not firing.
- Arithmetic is modulo 2^CTR_BITS: a counter at all-ones plus 1 becomes 0. active_threads at 2^CTR_BITS-2 plus 4 becomes 2. There is no saturation and no overflow flag.
- clear:
  - When high at a clk edge, all counters load 0.
  - Clear has priority over simultaneous events; the event in that cycle is dropped.
  - Counting resumes the cycle after clear deasserts.
- Events are independent: any combination, including all 7 stall events plus a fire, may update in the same cycle.
- disp_valid/disp_ready bits with X while reset is low are don't-care.
- Reset mid-count: outputs go to 0 immediately (asynchronous); there is no partial-update hazard.
- No handshake outputs: the block is purely observational and never backpressures.

Optional Feature:
- Macro ISSUE_PERF_FPU_EN.
- Defined: fpu_stalls counts disp_valid[1-based fpu bit, index 3] & ~disp_ready[3] per the rules above.
- Not defined:
  - fpu_stalls is tied to constant 0.
  - No fpu counter register is instantiated.
  - disp_valid[3]/disp_ready[3] are ignored; the port width stays 5.

Test Plan:
- Reset then idle: reset low 3 cycles, release, all inputs 0 for 10 cycles -> all 8 outputs remain 0.
- ibf/scb stalls: decode_valid=1, ibuf_ready=0 for 7 cycles; ibuf_valid=1, scb_ready=0 for 3 of those -> ibf_stalls=7, scb_stalls=3, one cycle after the last event.
- Per-unit dispatch: disp_valid=5'b11111, disp_ready=5'b00101 for 4 cycles -> csr=4, fpu=4 (0 if macro undefined), gpu=4, lsu=0, alu=0.
- Active threads: 3 fires with tmask 4'b1111, 4'b0101, 4'b0001, plus 1 cycle issue_valid=1/issue_ready=0 with 4'b1111 -> active_threads=7.
- Wrap and clear priority: preload via 2^CTR_BITS-1 ibf events (or force) then 1 event -> ibf_stalls=0; clear=1 coincident with a scb event -> scb_stalls=0 next cycle.
- Async reset mid-count: assert reset between clk edges while counters are nonzero -> outputs 0 before the next clk edge.
